digit_pattern_gen: RTL and testbench
====================================

DIGIT_PATTERN_GEN -- requirements
Module: digit_pattern_gen

Interface
REQ-001 SHALL have parameter N_DIGITS, default 6, number of digits.
REQ-002 SHALL have parameter DIGIT_W, default 4, bits per digit.
REQ-003 SHALL have parameter MAX_VAL, default 9, largest digit value; range 1..2^DIGIT_W-1.
REQ-004 SHALL have parameter TICK_DIV, default 25000000, clk cycles per pattern step; minimum 1.
REQ-005 SHALL have port clk  in  1  single clock, rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port mode_valid  in  1  mode request.
REQ-008 SHALL have port mode  in  4  requested mode code.
REQ-009 SHALL have port mode_ready  out  1  request accepted when mode_valid and mode_ready are both high.
REQ-010 SHALL have port load_val  in  DIGIT_W  value for LOAD mode.
REQ-011 SHALL have port cur_mode  out  4  mode currently executing.
REQ-012 SHALL have port digit_ctrl  out  N_DIGITS*DIGIT_W  digit i at bits [i*DIGIT_W +: DIGIT_W].
REQ-013 SHALL have port wrap  out  1  one-cycle pulse on a pattern wrap.

Function
REQ-014 Prescaler SHALL count 0..TICK_DIV-1; step asserts for one cycle when count = TICK_DIV-1.
REQ-015 Handshake: accepted mode SHALL latch into a pending register; mode_ready SHALL be low while a request is pending.
REQ-016 On the first step after acceptance: cur_mode SHALL take the pending value; phase and pos SHALL reset to 0; that step SHALL execute the new mode; mode_ready SHALL return high the next cycle.
REQ-017 Acceptance and step in the same cycle SHALL defer the new mode to the following step.
REQ-018 Digits SHALL change only on step cycles.
REQ-019 Mode 0 HOLD: no change.
REQ-020 Mode 1 LOAD: every digit <= min(load_val, MAX_VAL).
REQ-021 Mode 2 INC: every digit +1; MAX_VAL wraps to 0. Mode 3 DEC: every digit -1; 0 wraps to MAX_VAL.
REQ-022 Mode 4 ROTL: digit[i] <= digit[i-1]; digit[0] <= digit[N_DIGITS-1]. Mode 5 ROTR is the mirror image.
REQ-023 Mode 6 COMPL: every digit <= MAX_VAL - digit.
REQ-024 Mode 7 MIRROR: digits 0..N_DIGITS/2-1 <= phase; the remaining digits <= MAX_VAL - phase; phase then increments 0..MAX_VAL and wraps to 0.
REQ-025 Mode 8 CHASE_L: digit[pos] <= val; pos increments 0..N_DIGITS-1. At N_DIGITS-1, pos returns to 0 and val increments 0..MAX_VAL with wrap. Mode 9 CHASE_R: identical but writes digit[N_DIGITS-1-pos].
REQ-026 Modes 10-15 SHALL clear all digits to 0 on each step.
REQ-027 wrap SHALL pulse on the step where any of the following occurs: INC/DEC digit[0] wraps; MIRROR phase returns to 0; CHASE val returns to 0.
REQ-028 A digit whose value is greater than MAX_VAL entering INC/DEC/COMPL SHALL be treated as MAX_VAL.
REQ-029 digit_ctrl SHALL be driven directly from registers (no combinational path from inputs).

Reset
REQ-030 While rst is high, all of the following SHALL hold: digits 0, cur_mode 0, pending cleared, mode_ready 1, wrap 0, prescaler 0, phase 0, pos 0, val 0.
REQ-031 Reset asserted mid-pattern SHALL take effect asynchronously and discard any pending mode.

Configuration
REQ-032 With DIGIT_PATTERN_BLINK_EN defined: SHALL add input blink_mask[N_DIGITS-1:0] and output digit_blank[N_DIGITS-1:0].
REQ-033 With DIGIT_PATTERN_BLINK_EN defined: a blink flag SHALL toggle on every step and reset to 0; digit_blank[i] = blink_mask[i] AND flag, registered.
REQ-034 Without DIGIT_PATTERN_BLINK_EN: neither port SHALL exist and no blink logic SHALL be present.

Verification (TICK_DIV=2, defaults otherwise)
REQ-035 Reset; request mode 1 with load_val=7 -> after the next step, digit_ctrl=0x777777 and cur_mode=1.
REQ-036 LOAD 8, then INC -> first step gives 0x999999 with wrap=0; second step gives 0x000000 with a single-cycle wrap=1.
REQ-037 LOAD 12 -> digit_ctrl=0x999999 (clamped).
REQ-038 MIRROR run until phase=3, then ROTL -> digits[0..5]=6,3,3,3,6,6 after the ROTL step.
REQ-039 Request mode 2, then immediately request mode 3 while pending -> mode_ready=0; second request not accepted until the cycle after the step that applies mode 2.
REQ-040 Assert rst mid-CHASE_L (pos=3) -> digit_ctrl=0 and mode_ready=1 immediately; after release, cur_mode=0 and digits hold.

Source files
------------

// File: rtl/digit_pattern_gen.sv
// Multi-digit pattern generator: a prescaled step drives one of 16 pattern modes over N_DIGITS digits.
// Optional per-digit blink output is enabled by defining DIGIT_PATTERN_BLINK_EN.
module digit_pattern_gen #(
    parameter int unsigned N_DIGITS = 6,
    parameter int unsigned DIGIT_W  = 4,
    parameter int unsigned MAX_VAL  = 9,
    parameter int unsigned TICK_DIV = 25000000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          mode_valid,
    input  logic [3:0]                    mode,
    output logic                          mode_ready,
    input  logic [DIGIT_W-1:0]            load_val,
    output logic [3:0]                    cur_mode,
    output logic [N_DIGITS*DIGIT_W-1:0]   digit_ctrl,
    output logic                          wrap
`ifdef DIGIT_PATTERN_BLINK_EN
    ,
    input  logic [N_DIGITS-1:0]           blink_mask,
    output logic [N_DIGITS-1:0]           digit_blank
`endif
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned POS_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned HALF  = N_DIGITS / 2;

    localparam logic [DIGIT_W-1:0] MAXV     = DIGIT_W'(MAX_VAL);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [POS_W-1:0]   POS_LAST = POS_W'(N_DIGITS - 1);

    localparam logic [3:0] MODE_HOLD    = 4'd0;
    localparam logic [3:0] MODE_LOAD    = 4'd1;
    localparam logic [3:0] MODE_INC     = 4'd2;
    localparam logic [3:0] MODE_DEC     = 4'd3;
    localparam logic [3:0] MODE_ROTL    = 4'd4;
    localparam logic [3:0] MODE_ROTR    = 4'd5;
    localparam logic [3:0] MODE_COMPL   = 4'd6;
    localparam logic [3:0] MODE_MIRROR  = 4'd7;
    localparam logic [3:0] MODE_CHASE_L = 4'd8;
    localparam logic [3:0] MODE_CHASE_R = 4'd9;

    logic [CNT_W-1:0]   presc;
    logic               step;
    logic               pend_valid;
    logic [3:0]         pend_mode;
    logic [DIGIT_W-1:0] phase;
    logic [POS_W-1:0]   pos;
    logic [DIGIT_W-1:0] val;

    logic [3:0]                  eff_mode;
    logic [DIGIT_W-1:0]          eff_phase;
    logic [POS_W-1:0]            eff_pos;
    logic [POS_W-1:0]            chase_idx;
    logic [N_DIGITS*DIGIT_W-1:0] digit_nxt;
    logic [DIGIT_W-1:0]          phase_nxt;
    logic [POS_W-1:0]            pos_nxt;
    logic [DIGIT_W-1:0]          val_nxt;
    logic                        wrap_nxt;

    // Out-of-range digits behave as MAX_VAL for arithmetic modes
    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
        return (d > MAXV) ? MAXV : d;
    endfunction

    function automatic logic [DIGIT_W-1:0] inc_digit(input logic [DIGIT_W-1:0] d);
        logic [DIGIT_W-1:0] c;
        c = clamp_digit(d);
        return (c == MAXV) ? '0 : c + DIGIT_W'(1);
    endfunction

    function automatic logic [DIGIT_W-1:0] dec_digit(input logic [DIGIT_W-1:0] d);
        logic [DIGIT_W-1:0] c;
        c = clamp_digit(d);
        return (c == '0) ? MAXV : c - DIGIT_W'(1);
    endfunction

    assign step = (presc == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (step) begin
            presc <= '0;
        end else begin
            presc <= presc + CNT_W'(1);
        end
    end

    // Accepted requests wait in pend_* until the next step applies them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_mode  <= '0;
            mode_ready <= 1'b1;
            cur_mode   <= '0;
        end else if (step && pend_valid) begin
            cur_mode   <= pend_mode;
            pend_valid <= 1'b0;
            mode_ready <= 1'b1;
        end else if (mode_valid && mode_ready) begin
            pend_mode  <= mode;
            pend_valid <= 1'b1;
            mode_ready <= 1'b0;
        end
    end

    // A mode switch restarts phase/pos and runs the new mode on the same step
    assign eff_mode  = pend_valid ? pend_mode : cur_mode;
    assign eff_phase = pend_valid ? '0 : phase;
    assign eff_pos   = pend_valid ? '0 : pos;

    always_comb begin
        digit_nxt = digit_ctrl;
        phase_nxt = eff_phase;
        pos_nxt   = eff_pos;
        val_nxt   = val;
        wrap_nxt  = 1'b0;
        chase_idx = (eff_mode == MODE_CHASE_R) ? (POS_LAST - eff_pos) : eff_pos;
        case (eff_mode)
            MODE_HOLD: ;
            MODE_LOAD: begin
                for (int unsigned i = 0; i < N_DIGITS; i++)
                    digit_nxt[i*DIGIT_W +: DIGIT_W] = clamp_digit(load_val);
            end
            MODE_INC: begin
                for (int unsigned i = 0; i < N_DIGITS; i++)
                    digit_nxt[i*DIGIT_W +: DIGIT_W] = inc_digit(digit_ctrl[i*DIGIT_W +: DIGIT_W]);
                wrap_nxt = (clamp_digit(digit_ctrl[DIGIT_W-1:0]) == MAXV);
            end
            MODE_DEC: begin
                for (int unsigned i = 0; i < N_DIGITS; i++)
                    digit_nxt[i*DIGIT_W +: DIGIT_W] = dec_digit(digit_ctrl[i*DIGIT_W +: DIGIT_W]);
                wrap_nxt = (clamp_digit(digit_ctrl[DIGIT_W-1:0]) == '0);
            end
            MODE_ROTL: begin
                for (int unsigned i = 0; i < N_DIGITS; i++)
                    digit_nxt[i*DIGIT_W +: DIGIT_W] =
                        digit_ctrl[((i + N_DIGITS - 1) % N_DIGITS)*DIGIT_W +: DIGIT_W];
            end
            MODE_ROTR: begin
                for (int unsigned i = 0; i < N_DIGITS; i++)
                    digit_nxt[i*DIGIT_W +: DIGIT_W] =
                        digit_ctrl[((i + 1) % N_DIGITS)*DIGIT_W +: DIGIT_W];
            end
            MODE_COMPL: begin
                for (int unsigned i = 0; i < N_DIGITS; i++)
                    digit_nxt[i*DIGIT_W +: DIGIT_W] =
                        MAXV - clamp_digit(digit_ctrl[i*DIGIT_W +: DIGIT_W]);
            end
            MODE_MIRROR: begin
                for (int unsigned i = 0; i < N_DIGITS; i++)
                    digit_nxt[i*DIGIT_W +: DIGIT_W] = (i < HALF) ? eff_phase : (MAXV - eff_phase);
                phase_nxt = (eff_phase == MAXV) ? '0 : eff_phase + DIGIT_W'(1);
                wrap_nxt  = (eff_phase == MAXV);
            end
            MODE_CHASE_L, MODE_CHASE_R: begin
                for (int unsigned i = 0; i < N_DIGITS; i++)
                    if (POS_W'(i) == chase_idx)
                        digit_nxt[i*DIGIT_W +: DIGIT_W] = val;
                if (eff_pos == POS_LAST) begin
                    pos_nxt  = '0;
                    val_nxt  = (val == MAXV) ? '0 : val + DIGIT_W'(1);
                    wrap_nxt = (val == MAXV);
                end else begin
                    pos_nxt = eff_pos + POS_W'(1);
                end
            end
            default: digit_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_ctrl <= '0;
            phase      <= '0;
            pos        <= '0;
            val        <= '0;
            wrap       <= 1'b0;
        end else begin
            wrap <= step && wrap_nxt;
            if (step) begin
                digit_ctrl <= digit_nxt;
                phase      <= phase_nxt;
                pos        <= pos_nxt;
                val        <= val_nxt;
            end
        end
    end

`ifdef DIGIT_PATTERN_BLINK_EN
    logic blink_flag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_flag  <= 1'b0;
            digit_blank <= '0;
        end else begin
            if (step) blink_flag <= ~blink_flag;
            digit_blank <= blink_mask & {N_DIGITS{blink_flag}};
        end
    end
`endif

endmodule

// File: tb/tb_digit_pattern_gen.sv
// Directed bench for digit_pattern_gen with TICK_DIV=2: vector table plus handshake/reset sequences.
module tb_digit_pattern_gen;

    localparam int unsigned TICK = 2;
    localparam int unsigned NV   = 19;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode_valid;
    logic [3:0]  mode;
    logic        mode_ready;
    logic [3:0]  load_val;
    logic [3:0]  cur_mode;
    logic [23:0] digit_ctrl;
    logic        wrap;
`ifdef DIGIT_PATTERN_BLINK_EN
    logic [5:0]  blink_mask = '0;
    logic [5:0]  digit_blank;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0]  mode;
        logic [3:0]  lv;
        int          extra;
        logic [23:0] exp_digits;
        logic        exp_wrap;
    } vec_t;

    vec_t vecs[NV];

    digit_pattern_gen #(
        .N_DIGITS(6), .DIGIT_W(4), .MAX_VAL(9), .TICK_DIV(TICK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mode_valid(mode_valid),
        .mode(mode),
        .mode_ready(mode_ready),
        .load_val(load_val),
        .cur_mode(cur_mode),
        .digit_ctrl(digit_ctrl),
        .wrap(wrap)
`ifdef DIGIT_PATTERN_BLINK_EN
        ,
        .blink_mask(blink_mask),
        .digit_blank(digit_blank)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge just after the step that applied m
    task automatic apply_mode(input logic [3:0] m, input logic [3:0] lv);
        int cnt;
        mode_valid = 1'b1;
        mode       = m;
        load_val   = lv;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (mode_ready && cnt < 20);
        if (mode_ready) begin
            tests++; fails++;
            $display("FAIL accept_timeout mode %0d: mode_ready stayed 1", m);
        end
        mode_valid = 1'b0;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!mode_ready && cnt < 20);
        if (!mode_ready) begin
            tests++; fails++;
            $display("FAIL apply_timeout mode %0d: mode_ready stayed 0", m);
        end
    endtask

    initial begin
        vecs[0]  = '{4'd1,  4'd7,  0, 24'h777777, 1'b0};
        vecs[1]  = '{4'd1,  4'd8,  0, 24'h888888, 1'b0};
        vecs[2]  = '{4'd2,  4'd0,  0, 24'h999999, 1'b0};
        vecs[3]  = '{4'd1,  4'd12, 0, 24'h999999, 1'b0};
        vecs[4]  = '{4'd3,  4'd0,  0, 24'h888888, 1'b0};
        vecs[5]  = '{4'd1,  4'd0,  0, 24'h000000, 1'b0};
        vecs[6]  = '{4'd3,  4'd0,  0, 24'h999999, 1'b1};
        vecs[7]  = '{4'd6,  4'd0,  0, 24'h000000, 1'b0};
        vecs[8]  = '{4'd1,  4'd3,  0, 24'h333333, 1'b0};
        vecs[9]  = '{4'd6,  4'd0,  1, 24'h333333, 1'b0};
        vecs[10] = '{4'd12, 4'd0,  0, 24'h000000, 1'b0};
        vecs[11] = '{4'd7,  4'd0,  3, 24'h666333, 1'b0};
        vecs[12] = '{4'd4,  4'd0,  0, 24'h663336, 1'b0};
        vecs[13] = '{4'd5,  4'd0,  0, 24'h666333, 1'b0};
        vecs[14] = '{4'd0,  4'd0,  2, 24'h666333, 1'b0};
        vecs[15] = '{4'd8,  4'd0,  2, 24'h666000, 1'b0};
        vecs[16] = '{4'd9,  4'd0,  0, 24'h066000, 1'b0};
        vecs[17] = '{4'd7,  4'd0,  9, 24'h000999, 1'b1};
        vecs[18] = '{4'd2,  4'd0,  0, 24'h111000, 1'b1};

        rst = 1'b1;
        mode_valid = 1'b0;
        mode = '0;
        load_val = '0;
        repeat (3) @(negedge clk);
        check("reset digits", 32'(digit_ctrl), 32'h0);
        check("reset cur_mode", 32'(cur_mode), 32'h0);
        check("reset mode_ready", 32'(mode_ready), 32'h1);
        check("reset wrap", 32'(wrap), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            apply_mode(vecs[i].mode, vecs[i].lv);
            repeat (TICK * vecs[i].extra) @(negedge clk);
            check($sformatf("vec%0d digits", i), 32'(digit_ctrl), 32'(vecs[i].exp_digits));
            check($sformatf("vec%0d cur_mode", i), 32'(cur_mode), 32'(vecs[i].mode));
            check($sformatf("vec%0d wrap", i), 32'(wrap), 32'(vecs[i].exp_wrap));
        end

        // wrap is a single-cycle pulse and digits hold between steps
        @(negedge clk);
        check("wrap pulse width", 32'(wrap), 32'h0);
        check("no change off-step", 32'(digit_ctrl), 32'h111000);
        @(negedge clk);
        check("inc next step", 32'(digit_ctrl), 32'h222111);
        apply_mode(4'd0, 4'd0);
        check("hold applied", 32'(digit_ctrl), 32'h222111);

        // second request held off while the first is pending
        mode_valid = 1'b1;
        mode = 4'd2;
        @(negedge clk);
        check("pending ready low", 32'(mode_ready), 32'h0);
        check("pending cur_mode", 32'(cur_mode), 32'h0);
        mode = 4'd3;
        @(negedge clk);
        check("applied ready high", 32'(mode_ready), 32'h1);
        check("applied cur_mode 2", 32'(cur_mode), 32'h2);
        check("applied inc digits", 32'(digit_ctrl), 32'h333222);
        @(negedge clk);
        check("second accepted", 32'(mode_ready), 32'h0);
        check("second not yet applied", 32'(cur_mode), 32'h2);
        mode_valid = 1'b0;
        @(negedge clk);
        check("second applied", 32'(cur_mode), 32'h3);
        check("dec digits", 32'(digit_ctrl), 32'h222111);

        // acceptance on a step cycle defers the new mode to the following step
        @(negedge clk);
        mode_valid = 1'b1;
        mode = 4'd1;
        load_val = 4'd5;
        @(negedge clk);
        check("step-accept ready", 32'(mode_ready), 32'h0);
        check("step-accept old mode", 32'(cur_mode), 32'h3);
        check("step-accept old step", 32'(digit_ctrl), 32'h111000);
        mode_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("deferred cur_mode", 32'(cur_mode), 32'h1);
        check("deferred digits", 32'(digit_ctrl), 32'h555555);

        // asynchronous reset mid-chase with a request pending
        apply_mode(4'd8, 4'd0);
        repeat (TICK * 2) @(negedge clk);
        check("chase pos3 digits", 32'(digit_ctrl), 32'h555000);
        mode_valid = 1'b1;
        mode = 4'd2;
        @(negedge clk);
        check("chase pending", 32'(mode_ready), 32'h0);
        #2 rst = 1'b1;
        #1;
        check("async rst digits", 32'(digit_ctrl), 32'h0);
        check("async rst ready", 32'(mode_ready), 32'h1);
        check("async rst cur_mode", 32'(cur_mode), 32'h0);
        mode_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("post rst cur_mode", 32'(cur_mode), 32'h0);
        check("post rst digits", 32'(digit_ctrl), 32'h0);
        check("post rst ready", 32'(mode_ready), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
